// File: rtl/la_progress_counter_pkg.sv
// Shared encodings and LA mailbox bit positions for the progress counter.
package la_progress_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_INC   = 2'd2,
        OP_ADD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int REQ_BIT       = 32;
    localparam int OP_LSB        = 33;
    localparam int RUN_BIT       = 35;
    localparam int PRE_LSB       = 36;
    localparam int TERM_LSB      = 52;
    localparam int ACK_BIT       = 32;
    localparam int DONE_BIT      = 33;
    localparam int RUNNING_BIT   = 34;
    localparam int STATE_LSB     = 35;
    localparam int PRE_FIELD_W   = 16;
    localparam int TERM_FIELD_W  = 6;
    localparam int IO_STEP_LSB   = 20;
    localparam int IO_STATUS_LSB = 16;

    // Pads 31:16 are driven outputs, everything else stays an input.
    localparam logic [37:0] IO_OEB_VAL = 38'h3F_0000_FFFF;

endpackage

// File: rtl/la_tick_gen.sv
// Reloadable down-counter prescaler: with reload value P it ticks once every P+1 enabled cycles.
module la_tick_gen #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             reload,
    input  logic [PRE_W-1:0] value,
    output logic             tick
);

    logic [PRE_W-1:0] count;

    assign tick = enable && !reload && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (reload || tick) begin
            count <= value;
        end else if (enable) begin
            count <= count - PRE_W'(1);
        end
    end

endmodule

// File: rtl/la_progress_counter.sv
// LA-commanded milestone counter: firmware loads/steps/free-runs cnt and the step field is shown on io_out[25:20].
module la_progress_counter
    import la_progress_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 6,
    parameter int PRE_W  = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    logic [127:0]     eff;
    logic             req;
    logic             run_en;
    logic             cmd;
    op_e              op;
    logic [CNT_W-1:0] operand;
    logic [PRE_W-1:0] pre_val;
    logic [STEP_W-1:0] term;

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             req_q;
    logic             ack;
    logic             irq_q;
    logic             tick_en;
    logic             tick;
    logic             done;
    logic             running;
    logic             unused_eff;

    assign eff        = la_data_in & ~la_oenb;
    assign req        = eff[REQ_BIT];
    assign run_en     = eff[RUN_BIT];
    assign op         = op_e'(eff[OP_LSB +: 2]);
    assign operand    = CNT_W'(eff[31:0]);
    assign pre_val    = PRE_W'(eff[PRE_LSB +: PRE_FIELD_W]);
    assign term       = STEP_W'(eff[TERM_LSB +: TERM_FIELD_W]);
    assign unused_eff = ^eff[127:58];

    assign cmd     = (req != req_q);
    assign cnt_inc = cnt + CNT_W'(1);

    // A command in the same cycle suppresses the tick and reloads the prescaler.
    assign tick_en = (state == ST_RUN) && run_en && !cmd;

    la_tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .enable (tick_en),
        .reload (!tick_en),
        .value  (pre_val),
        .tick   (tick)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cmd) begin
            state_nxt = run_en ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (run_en) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (!run_en) begin
                        state_nxt = ST_IDLE;
                    end else if (tick && (cnt_inc[STEP_W-1:0] == term)) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: if (!run_en) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        done    = (state == ST_DONE);
        running = (state == ST_RUN);
    end

    always_comb begin
        cnt_nxt = cnt;
        if (cmd) begin
            case (op)
                OP_CLEAR: cnt_nxt = '0;
                OP_LOAD:  cnt_nxt = operand;
                OP_INC:   cnt_nxt = cnt_inc;
                OP_ADD:   cnt_nxt = cnt + operand;
            endcase
        end else if (tick) begin
            cnt_nxt = cnt_inc;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt   <= '0;
            req_q <= 1'b0;
            ack   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            req_q <= req;
            ack   <= ack ^ cmd;
            irq_q <= (state == ST_RUN) && (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        la_data_out                        = '0;
        la_data_out[CNT_W-1:0]             = cnt;
        la_data_out[ACK_BIT]               = ack;
        la_data_out[DONE_BIT]              = done;
        la_data_out[RUNNING_BIT]           = running;
        la_data_out[STATE_LSB +: 2]        = state;
        io_out                             = '0;
        io_out[IO_STEP_LSB +: STEP_W]      = cnt[STEP_W-1:0];
        io_out[IO_STATUS_LSB +: 4]         = {done, running, state};
        io_oeb                             = IO_OEB_VAL;
        irq                                = {2'b00, irq_q};
    end

endmodule

// File: tb/tb_la_progress_counter.sv
// Randomized scoreboard bench for la_progress_counter with a cycle-level behavioural reference model.
module tb_la_progress_counter;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic [127:0] oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [127:0] lado;
        logic [37:0]  io;
        logic [2:0]   irq;
    } exp_t;

    exp_t exp_q[$];

    la_progress_counter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .la_data_in  (din),
        .la_oenb     (oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
        end
    endtask

    // Reference model: mode 0/1/2 = idle/run/done; a tick fires once 'since' reaches the latched period.
    logic [31:0] m_cnt;
    logic        m_ack, m_req_q, m_irq;
    int          mode, since, period;

    always @(posedge clk) begin : model
        logic [127:0] e;
        logic         r, run;
        logic [1:0]   op;
        logic [31:0]  opnd;
        int           p;
        logic [5:0]   term;
        exp_t         x;
        e    = din & ~oenb;
        r    = e[32];
        op   = e[34:33];
        run  = e[35];
        opnd = e[31:0];
        p    = int'(e[51:36]);
        term = e[57:52];
        if (rst) begin
            m_cnt = 0; m_ack = 0; m_req_q = 0; m_irq = 0;
            mode = 0; since = 0; period = 0;
        end else begin
            m_irq = 0;
            if (r != m_req_q) begin
                case (op)
                    2'd0: m_cnt = 0;
                    2'd1: m_cnt = opnd;
                    2'd2: m_cnt = m_cnt + 1;
                    default: m_cnt = m_cnt + opnd;
                endcase
                m_ack  = !m_ack;
                mode   = run ? 1 : 0;
                since  = 0;
                period = p;
            end else if (mode == 1 && run) begin
                if (since == period) begin
                    m_cnt  = m_cnt + 1;
                    since  = 0;
                    period = p;
                    if (m_cnt[5:0] == term) begin
                        mode  = 2;
                        m_irq = 1;
                    end
                end else begin
                    since++;
                end
            end else begin
                if (mode == 1 && !run) mode = 0;
                else if (mode == 0 && run) mode = 1;
                else if (mode == 2 && !run) mode = 0;
                since  = 0;
                period = p;
            end
            m_req_q = r;
        end
        x.lado          = '0;
        x.lado[31:0]    = m_cnt;
        x.lado[32]      = m_ack;
        x.lado[33]      = (mode == 2);
        x.lado[34]      = (mode == 1);
        x.lado[36:35]   = mode[1:0];
        x.io            = '0;
        x.io[25:20]     = m_cnt[5:0];
        x.io[19:16]     = {mode == 2, mode == 1, mode[1:0]};
        x.irq           = {2'b00, m_irq};
        exp_q.push_back(x);
    end

    always @(negedge clk) begin : monitor
        exp_t        x;
        logic [37:0] oeb_want;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            for (int i = 0; i < 38; i++) oeb_want[i] = !(i >= 16 && i <= 31);
            check("la_data_out", la_data_out, x.lado);
            check("io_out", 128'(io_out), 128'(x.io));
            check("io_oeb", 128'(io_oeb), 128'(oeb_want));
            check("irq", 128'(irq), 128'(x.irq));
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] opnd, input logic run,
                         input logic [15:0] pre, input logic [5:0] term);
        @(negedge clk);
        din[31:0]  = opnd;
        din[34:33] = op;
        din[35]    = run;
        din[51:36] = pre;
        din[57:52] = term;
        din[32]    = ~din[32];
        @(negedge clk);
    endtask

    initial begin : stim
        int irq_seen;
        bit found;
        rst  = 1'b1;
        din  = '0;
        oenb = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Everything gated off: a req toggle must not act.
        din[32] = 1'b1;
        din[33] = 1'b1;
        repeat (3) @(negedge clk);
        check("gated_lado", la_data_out, 128'h0);
        check("gated_step", 128'(io_out[25:20]), 128'h0);
        din  = '0;
        @(negedge clk);
        oenb = '0;
        @(negedge clk);

        issue(2'd1, 32'h1F, 1'b0, 16'd0, 6'd0);
        check("load_cnt", 128'(la_data_out[31:0]), 128'h1F);
        check("load_ack", 128'(la_data_out[32]), 128'h1);
        issue(2'd2, 32'h0, 1'b0, 16'd0, 6'd0);
        check("inc_cnt", 128'(la_data_out[31:0]), 128'h20);
        check("inc_ack", 128'(la_data_out[32]), 128'h0);

        // Free run to terminal step 32 with a tick every 4 cycles.
        issue(2'd0, 32'h0, 1'b1, 16'd3, 6'd32);
        irq_seen = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (irq[0]) irq_seen++;
        end
        check("done_step", 128'(io_out[25:20]), 128'd32);
        check("done_status", 128'(io_out[19:16]), 128'b1010);
        check("done_irq_count", 128'(irq_seen), 128'd1);
        check("done_frozen", 128'(la_data_out[31:0]), 128'd32);

        din[35] = 1'b0;
        issue(2'd1, 32'hFFFF_FFFF, 1'b0, 16'd0, 6'd0);
        issue(2'd3, 32'h2, 1'b0, 16'd0, 6'd0);
        check("wrap_cnt", 128'(la_data_out[31:0]), 128'd1);
        check("wrap_step", 128'(io_out[25:20]), 128'd1);

        // Command on the same edge as a tick.
        issue(2'd0, 32'h0, 1'b1, 16'd0, 6'd63);
        issue(2'd2, 32'h0, 1'b1, 16'd0, 6'd63);
        check("cmd_tick_once", 128'(la_data_out[31:0]), 128'd2);
        @(negedge clk);
        check("tick_after_cmd", 128'(la_data_out[31:0]), 128'd3);

        // Reset in the middle of a run at step 17.
        issue(2'd0, 32'h0, 1'b1, 16'd0, 6'd63);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (io_out[25:20] == 6'd17) found = 1;
            else @(negedge clk);
        end
        check("reach_step17", 128'(found), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_lado", la_data_out, 128'h0);
        check("rst_io", 128'(io_out), 128'h0);
        check("rst_irq", 128'(irq), 128'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized phase.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            din[127:58] = {$urandom, $urandom, 6'($urandom)};
            oenb = ($urandom_range(0, 49) == 0) ? {70'h0, 26'($urandom), $urandom} : '0;
            if ($urandom_range(0, 29) == 0) din[35] = ~din[35];
            if ($urandom_range(0, 19) == 0) begin
                din[31:0]  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 70));
                din[34:33] = 2'($urandom);
                din[51:36] = 16'($urandom_range(0, 3));
                din[57:52] = 6'($urandom);
                din[32]    = ~din[32];
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
